// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw key pins in, debounced level and pulses out.
interface key_conditioner_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] keys_i;
  logic [N_KEYS-1:0] key_state_o;
  logic [N_KEYS-1:0] key_press_o;
  logic [N_KEYS-1:0] key_release_o;

  modport master (output keys_i, input key_state_o, key_press_o, key_release_o);
  modport slave  (input keys_i, output key_state_o, key_press_o, key_release_o);
endinterface

// File: rtl/key_conditioner.sv
// Synchronises and debounces N_KEYS push-buttons into a clean level plus press/release pulses.
// Define KEY_REPEAT_EN to add auto-repeat press pulses while a key stays held.
module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REPEAT_DELAY    = 13500000,
  parameter int REPEAT_PERIOD   = 2700000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  key_conditioner_if.slave kif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [N_KEYS-1:0] IDLE_LEVEL = {N_KEYS{ACTIVE_LOW}};

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic [N_KEYS-1:0] sync1_reg, sync2_reg, sync_k;

  // Synchronisers idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_reg <= IDLE_LEVEL;
      sync2_reg <= IDLE_LEVEL;
    end else begin
      sync1_reg <= kif.keys_i;
      sync2_reg <= sync1_reg;
    end
  end

  assign sync_k = ACTIVE_LOW ? ~sync2_reg : sync2_reg;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          level_reg, level_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic          press_accept, release_accept, rep_fire;

    assign press_accept   = (state_reg == PRESS_WAIT)   &&  sync_k[gi] && (cnt_reg == CNT_MAX);
    assign release_accept = (state_reg == RELEASE_WAIT) && !sync_k[gi] && (cnt_reg == CNT_MAX);

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt_reg, rep_cnt_next, rep_inc, rep_limit;
    logic          rep_first_reg, rep_first_next;

    // rep_first selects the initial delay; afterwards the shorter period applies.
    always_comb begin
      rep_cnt_next   = rep_cnt_reg;
      rep_first_next = rep_first_reg;
      rep_fire       = 1'b0;
      rep_inc        = rep_cnt_reg + 1'b1;
      rep_limit      = rep_first_reg ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
      if (press_accept) begin
        rep_cnt_next   = '0;
        rep_first_next = 1'b1;
      end else if (state_reg == HELD || state_reg == RELEASE_WAIT) begin
        if (rep_inc == rep_limit) begin
          rep_fire       = !release_accept;
          rep_cnt_next   = '0;
          rep_first_next = 1'b0;
        end else begin
          rep_cnt_next = rep_inc;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rep_cnt_reg   <= '0;
        rep_first_reg <= 1'b1;
      end else begin
        rep_cnt_reg   <= rep_cnt_next;
        rep_first_reg <= rep_first_next;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      level_next   = level_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state_reg)
        IDLE: if (sync_k[gi]) begin
          state_next = PRESS_WAIT;
          cnt_next   = CW'(1);
        end
        PRESS_WAIT: if (!sync_k[gi]) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (press_accept) begin
          state_next = HELD;
          cnt_next   = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
        HELD: if (!sync_k[gi]) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CW'(1);
        end
        RELEASE_WAIT: if (sync_k[gi]) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (release_accept) begin
          state_next   = IDLE;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
      if (rep_fire) press_next = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        state_reg   <= state_next;
        cnt_reg     <= cnt_next;
        level_reg   <= level_next;
        press_reg   <= press_next;
        release_reg <= release_next;
      end
    end

    assign kif.key_state_o[gi]   = level_reg;
    assign kif.key_press_o[gi]   = press_reg;
    assign kif.key_release_o[gi] = release_reg;
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench: clean press/release, bounce, simultaneous keys, reset mid-hold, auto-repeat.
module tb_key_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  always #5 clk = ~clk;

  key_conditioner_if #(.N_KEYS(3)) kif_a ();
  key_conditioner_if #(.N_KEYS(3)) kif_b ();

  key_conditioner #(.N_KEYS(3), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
                    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .kif(kif_a));

  key_conditioner #(.N_KEYS(3), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(2),
                    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .kif(kif_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Step n edges of dut_a; edge index 0 is the first posedge after the call.
  task automatic run_edges(input string tag, input int n, input int pulse_edge,
                           input logic [2:0] bits, input logic [2:0] st_before,
                           input logic [2:0] st_after, input bit is_press);
    logic [2:0] exp_p, exp_r, exp_s;
    for (int e = 0; e < n; e++) begin
      @(posedge clk);
      #1;
      exp_p = (is_press  && e == pulse_edge) ? bits : 3'b000;
      exp_r = (!is_press && e == pulse_edge) ? bits : 3'b000;
      exp_s = (pulse_edge >= 0 && e >= pulse_edge) ? st_after : st_before;
      check({tag, "_press"},   {29'd0, kif_a.key_press_o},   {29'd0, exp_p});
      check({tag, "_release"}, {29'd0, kif_a.key_release_o}, {29'd0, exp_r});
      check({tag, "_state"},   {29'd0, kif_a.key_state_o},   {29'd0, exp_s});
    end
  endtask

  initial begin
    logic [2:0] exp_p;
    kif_a.keys_i = 3'b111;
    kif_b.keys_i = 3'b111;
    #12;
    check("rst_state",   {29'd0, kif_a.key_state_o},   32'd0);
    check("rst_press",   {29'd0, kif_a.key_press_o},   32'd0);
    check("rst_release", {29'd0, kif_a.key_release_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_edges("idle", 4, -1, 3'b000, 3'b000, 3'b000, 1'b1);
    $display("reset and idle done");

    kif_a.keys_i = 3'b110;
    run_edges("clean_p", 9, 6, 3'b001, 3'b000, 3'b001, 1'b1);
    kif_a.keys_i = 3'b111;
    run_edges("clean_r", 9, 6, 3'b001, 3'b001, 3'b000, 1'b0);
    $display("clean press/release done");

    kif_a.keys_i = 3'b110;
    run_edges("bounce_lo", 3, -1, 3'b000, 3'b000, 3'b000, 1'b1);
    kif_a.keys_i = 3'b111;
    run_edges("bounce_hi", 1, -1, 3'b000, 3'b000, 3'b000, 1'b1);
    kif_a.keys_i = 3'b110;
    run_edges("bounce_p", 9, 6, 3'b001, 3'b000, 3'b001, 1'b1);
    kif_a.keys_i = 3'b111;
    run_edges("bounce_r", 9, 6, 3'b001, 3'b001, 3'b000, 1'b0);
    $display("bounce rejection done");

    kif_a.keys_i = 3'b010;
    run_edges("simul_p", 9, 6, 3'b101, 3'b000, 3'b101, 1'b1);
    kif_a.keys_i = 3'b111;
    run_edges("simul_r", 9, 6, 3'b101, 3'b101, 3'b000, 1'b0);
    $display("simultaneous keys done");

    kif_a.keys_i = 3'b110;
    run_edges("hold_p", 9, 6, 3'b001, 3'b000, 3'b001, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_state",   {29'd0, kif_a.key_state_o},   32'd0);
    check("async_release", {29'd0, kif_a.key_release_o}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("inrst_state",   {29'd0, kif_a.key_state_o},   32'd0);
      check("inrst_release", {29'd0, kif_a.key_release_o}, 32'd0);
      check("inrst_press",   {29'd0, kif_a.key_press_o},   32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_edges("post_rst_p", 9, 6, 3'b001, 3'b000, 3'b001, 1'b1);
    kif_a.keys_i = 3'b111;
    run_edges("post_rst_r", 9, 6, 3'b001, 3'b001, 3'b000, 1'b0);
    $display("reset mid-hold done");

    // dut_b: accept A at edge 4, release accepted at edge 34 (A+30) where a repeat is due.
    @(posedge clk);
    #1;
    kif_b.keys_i = 3'b110;
    for (int e = 0; e < 46; e++) begin
      @(posedge clk);
      #1;
      exp_p = (e == 4 || (REP && (e == 14 || e == 19 || e == 24 || e == 29))) ? 3'b001 : 3'b000;
      check("rep_press",   {29'd0, kif_b.key_press_o},   {29'd0, exp_p});
      check("rep_release", {29'd0, kif_b.key_release_o}, (e == 34) ? 32'd1 : 32'd0);
      check("rep_state",   {29'd0, kif_b.key_state_o},   (e >= 4 && e < 34) ? 32'd1 : 32'd0);
      if (e == 29) kif_b.keys_i = 3'b111;
    end
    $display("repeat test done (repeat enabled = %0d)", REP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
